// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   - Default clock / line rate used to derive the bit divider.
//   - Frame geometry for 8N1: 8 data bits, 10 line bits per frame.
//   - Serializer state encoding.
package uart_pkg;

   localparam int CLK_FREQ_DEFAULT  = 50000000;
   localparam int BAUD_RATE_DEFAULT = 115200;

   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS = 10;  // start + 8 data + stop

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud tick generator for the UART transmitter.
// Counts 0..BAUD_DIV-1 while enabled and emits a one-cycle tick when the
// count reaches BAUD_DIV-1. While disabled the counter is parked at 0 so the
// next frame always starts with a full-length first bit.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous reset, active HIGH despite the name
//   en     in   run enable (high while a frame is in flight)
//   tick   out  one-cycle pulse at the last cycle of each bit period
module uart_baud_tick #(
   parameter int BAUD_DIV = 434
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          at_last;

   assign at_last = (cnt_q == CNT_LAST);
   assign tick    = en && at_last;

   always_comb begin
      cnt_d = '0;
      if (en) begin
         cnt_d = at_last ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter.
// A start strobe in IDLE latches a byte and sends: start bit (0), 8 data
// bits LSB first, stop bit (1), each BAUD_DIV cycles long. A one-cycle done
// pulse marks the end of the stop bit; the line is already idle by then, and
// a new start in that same cycle is accepted so frames can run back to back.
//
// Handshake: i_tx_start is a level sampled on every clock edge; it is only
// acted on in IDLE, so strobes (held or repeated) during a frame are ignored.
// i_data is sampled only on the edge that accepts a start.
//
// Ports:
//   clk                   in   system clock, rising edge
//   rst_n                 in   synchronous reset, active HIGH despite the name
//   i_tx_start            in   start strobe
//   i_data[7:0]           in   byte to send
//   o_rs232_txd           out  serial line, idles high, registered
//   o_baudrate_tx_clk_en  out  high while a frame is in flight, registered
//   o_tx_done             out  one-cycle pulse at end of stop bit, registered
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = CLK_FREQ_DEFAULT,
   parameter int BAUD_RATE = BAUD_RATE_DEFAULT,
   parameter int BAUD_DIV  = CLK_FREQ / BAUD_RATE
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_tx_start,
   input  logic [7:0] i_data,
   output logic       o_rs232_txd,
   output logic       o_baudrate_tx_clk_en,
   output logic       o_tx_done
);

   localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

   state_t     state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [3:0] bit_idx_q, bit_idx_d;
   logic       txd_q, txd_d;
   logic       en_q, en_d;
   logic       done_q, done_d;
   logic       tick;

   uart_baud_tick #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en_q),
      .tick  (tick)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      txd_d     = txd_q;
      en_d      = en_q;
      done_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            txd_d = 1'b1;
            en_d  = 1'b0;
            if (i_tx_start) begin
               // Start bit goes out on the very next cycle; the baud counter
               // is already parked at 0 because the enable was low.
               state_d   = SEND;
               shift_d   = i_data;
               bit_idx_d = '0;
               txd_d     = 1'b0;
               en_d      = 1'b1;
            end
         end
         SEND: begin
            if (tick) begin
               if (bit_idx_q == LAST_BIT) begin
                  state_d   = IDLE;
                  bit_idx_d = '0;
                  txd_d     = 1'b1;
                  en_d      = 1'b0;
                  done_d    = 1'b1;
               end else begin
                  // Shift in ones from the top: after the 8 data bits have
                  // gone out the register is all ones, which supplies the
                  // stop bit without a separate mux leg.
                  bit_idx_d = bit_idx_q + 4'd1;
                  txd_d     = shift_q[0];
                  shift_d   = {1'b1, shift_q[7:1]};
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         txd_q     <= 1'b1;
         en_q      <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         txd_q     <= txd_d;
         en_q      <= en_d;
         done_q    <= done_d;
      end
   end

   assign o_rs232_txd          = txd_q;
   assign o_baudrate_tx_clk_en = en_q;
   assign o_tx_done            = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer. Two instances: one with a short divider (16)
// for most scenarios and one with the default divider (434).
// Time convention: T is the clock edge that samples an accepted start; the
// interval following edge n is called cycle n+1, so the start bit occupies
// cycles T+1..T+D and done is seen in cycle T+1+10*D.
module tb_uart_tx_serializer;

   localparam int D1 = 16;
   localparam int D2 = 434;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       st1 = 1'b0, st2 = 1'b0;
   logic [7:0] d1 = 8'h00, d2 = 8'h00;
   logic       txd1, en1, done1;
   logic       txd2, en2, done2;

   int cyc = 0;
   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   uart_tx_serializer #(.BAUD_DIV(D1)) dut1 (
      .clk                  (clk),
      .rst_n                (rst),
      .i_tx_start           (st1),
      .i_data               (d1),
      .o_rs232_txd          (txd1),
      .o_baudrate_tx_clk_en (en1),
      .o_tx_done            (done1)
   );

   uart_tx_serializer dut2 (
      .clk                  (clk),
      .rst_n                (rst),
      .i_tx_start           (st2),
      .i_data               (d2),
      .o_rs232_txd          (txd2),
      .o_baudrate_tx_clk_en (en2),
      .o_tx_done            (done2)
   );

   // ---------------- behavioural model ----------------
   // pos = cycles elapsed since the accepting edge (-1 when idle).
   typedef struct {
      int         pos;
      logic [7:0] data;
      logic       done;
   } mdl_t;

   mdl_t m1 = '{pos: -1, data: 8'h00, done: 1'b0};
   mdl_t m2 = '{pos: -1, data: 8'h00, done: 1'b0};

   function automatic mdl_t mstep(mdl_t m, logic r, logic s, logic [7:0] d, int dv);
      mdl_t n = m;
      n.done = 1'b0;
      if (r) begin
         n.pos = -1;
      end else if (m.pos < 0) begin
         if (s) begin
            n.pos  = 0;
            n.data = d;
         end
      end else begin
         n.pos = m.pos + 1;
         if (n.pos == 10 * dv) begin
            n.pos  = -1;
            n.done = 1'b1;
         end
      end
      return n;
   endfunction

   function automatic logic exp_txd(mdl_t m, int dv);
      int k;
      if (m.pos < 0) return 1'b1;
      k = m.pos / dv;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return m.data[k-1];
   endfunction

   always @(posedge clk) begin
      m1 = mstep(m1, rst, st1, d1, D1);
      m2 = mstep(m2, rst, st2, d2, D2);
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc + 1);
      end
   endtask

   logic tr_txd1[int];
   logic tr_en1[int];
   logic tr_txd2[int];
   int   dq1[$];
   int   dq2[$];

   always @(negedge clk) begin
      if (cyc > 0) begin
         tr_txd1[cyc+1] = txd1;
         tr_en1[cyc+1]  = en1;
         tr_txd2[cyc+1] = txd2;
         if (done1 === 1'b1) dq1.push_back(cyc + 1);
         if (done2 === 1'b1) dq2.push_back(cyc + 1);
         chk("txd1", 32'(txd1), 32'(exp_txd(m1, D1)));
         chk("en1", 32'(en1), 32'(m1.pos >= 0));
         chk("done1", 32'(done1), 32'(m1.done));
         chk("txd2", 32'(txd2), 32'(exp_txd(m2, D2)));
         chk("en2", 32'(en2), 32'(m2.pos >= 0));
         chk("done2", 32'(done2), 32'(m2.done));
      end
   end

   // ---------------- drivers ----------------
   task automatic pulse(input int which, input logic [7:0] d, output int t);
      @(posedge clk);
      #1;
      if (which == 1) begin st1 = 1'b1; d1 = d; end
      else            begin st2 = 1'b1; d2 = d; end
      @(posedge clk);
      #1;
      t = cyc;
      st1 = 1'b0;
      st2 = 1'b0;
   endtask

   // Line level at the centre of each of the 10 bits; exp[k] is frame bit k.
   task automatic check_centres(input int which, input int t, input int dv,
                                input logic [9:0] exp, input string nm);
      for (int k = 0; k < 10; k++) begin
         int   c;
         logic a;
         c = t + 1 + k * dv + dv / 2;
         a = (which == 1) ? tr_txd1[c] : tr_txd2[c];
         chk($sformatf("%s_bit%0d", nm, k), 32'(a), 32'(exp[k]));
      end
   endtask

   initial begin
      int t;
      int nd;

      // Reset held in idle.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_idle_txd", 32'(txd1), 32'd1);
      chk("rst_idle_en", 32'(en1), 32'd0);
      chk("rst_idle_done", 32'(done1), 32'd0);
      rst = 1'b0;
      repeat (3) @(posedge clk);

      // Reset mid-frame: frame aborted, no done pulse.
      pulse(1, 8'hC3, t);
      repeat (40) @(posedge clk);
      #1 rst = 1'b1;
      nd = dq1.size();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mid_txd", 32'(txd1), 32'd1);
      chk("rst_mid_en", 32'(en1), 32'd0);
      chk("rst_mid_done", 32'(done1), 32'd0);
      rst = 1'b0;
      repeat (200) @(posedge clk);
      chk("rst_mid_no_done", 32'(dq1.size()), 32'(nd));

      // Single frame A5.
      nd = dq1.size();
      pulse(1, 8'hA5, t);
      repeat (10 * D1 + 10) @(posedge clk);
      check_centres(1, t, D1, 10'b1101001010, "a5");
      chk("a5_done_cnt", 32'(dq1.size() - nd), 32'd1);
      chk("a5_done_cyc", 32'(dq1[$] - t), 32'd161);
      chk("a5_en_pre", 32'(tr_en1[t]), 32'd0);
      chk("a5_en_first", 32'(tr_en1[t+1]), 32'd1);
      chk("a5_en_last", 32'(tr_en1[t+160]), 32'd1);
      chk("a5_en_after", 32'(tr_en1[t+161]), 32'd0);

      // Edge values.
      pulse(1, 8'h00, t);
      repeat (10 * D1 + 10) @(posedge clk);
      check_centres(1, t, D1, 10'b1000000000, "x00");
      chk("x00_done_cyc", 32'(dq1[$] - t), 32'd161);
      pulse(1, 8'hFF, t);
      repeat (10 * D1 + 10) @(posedge clk);
      check_centres(1, t, D1, 10'b1111111110, "xff");
      chk("xff_start_end", 32'(tr_txd1[t+16]), 32'd0);
      chk("xff_d0_begin", 32'(tr_txd1[t+17]), 32'd1);
      chk("xff_done_cyc", 32'(dq1[$] - t), 32'd161);

      // Strobe while busy is ignored.
      nd = dq1.size();
      pulse(1, 8'hA5, t);
      repeat (49) @(posedge clk);
      #1 st1 = 1'b1; d1 = 8'h3C;
      @(posedge clk);
      #1 st1 = 1'b0; d1 = 8'h99;
      repeat (10 * D1 + 20) @(posedge clk);
      check_centres(1, t, D1, 10'b1101001010, "busy");
      chk("busy_done_cnt", 32'(dq1.size() - nd), 32'd1);
      chk("busy_done_cyc", 32'(dq1[$] - t), 32'd161);

      // Back-to-back with start held; data changes mid-frame.
      nd = dq1.size();
      @(posedge clk);
      #1 st1 = 1'b1; d1 = 8'h55;
      @(posedge clk);
      #1 t = cyc; d1 = 8'h0F;
      repeat (161) @(posedge clk);
      #1 st1 = 1'b0;
      repeat (10 * D1 + 20) @(posedge clk);
      chk("b2b_done_cnt", 32'(dq1.size() - nd), 32'd2);
      chk("b2b_done1", 32'(dq1[nd] - t), 32'd161);
      chk("b2b_done2", 32'(dq1[nd+1] - t), 32'd322);
      chk("b2b_gap_line", 32'(tr_txd1[t+161]), 32'd1);
      chk("b2b_start2", 32'(tr_txd1[t+162]), 32'd0);
      check_centres(1, t, D1, 10'b1010101010, "b2b55");
      check_centres(1, t + 161, D1, 10'b1000011110, "b2b0f");

      // Randomized frames with random extra strobes during the frame.
      for (int i = 0; i < 8; i++) begin
         pulse(1, 8'($urandom), t);
         repeat ($urandom_range(10, 200)) begin
            @(posedge clk);
            #1;
            st1 = ($urandom_range(0, 5) == 0);
            d1  = 8'($urandom);
         end
         #1 st1 = 1'b0;
         repeat ($urandom_range(0, 10)) @(posedge clk);
      end
      repeat (10 * D1 + 10) @(posedge clk);

      // Default divider.
      nd = dq2.size();
      pulse(2, 8'h41, t);
      repeat (10 * D2 + 20) @(posedge clk);
      check_centres(2, t, D2, 10'b1010000010, "div434");
      chk("div434_done_cnt", 32'(dq2.size() - nd), 32'd1);
      chk("div434_done_cyc", 32'(dq2[$] - t), 32'd4341);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- 8N1 UART transmitter: accepts a byte on a start strobe and serializes it on a single RS-232 TX line: start bit, 8 data bits LSB first, stop bit.
- Contains an internal baud-tick generator that runs only while a frame is in flight.
- Sits between on-chip byte producers and the board-level TX pin; reports completion with a one-cycle done pulse.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate in bits per second.
- BAUD_DIV, CLK_FREQ/BAUD_RATE (434 at the defaults), clock cycles per bit. Legal range is 2 or greater; the bench overrides it directly.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-high reset. The name follows the codebase; the polarity is high despite the suffix.
- i_tx_start  in  1  start strobe, sampled each clk.
- i_data  in  8  byte to send; sampled only in the cycle a start is accepted.
- o_rs232_txd  out  1  serial line; idle level is 1.
- o_baudrate_tx_clk_en  out  1  high while a frame is in flight; enables the baud generator.
- o_tx_done  out  1  one-cycle pulse at the end of the stop bit.

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - o_rs232_txd=1, o_baudrate_tx_clk_en=0, o_tx_done=0.
  - Baud counter=0, bit index=0, state IDLE.
  - Reset mid-frame aborts the frame immediately; no done pulse is issued.
- States: IDLE and SEND. Let D=BAUD_DIV.
- IDLE:
  - Line is held at 1 and the enable is 0.
  - If i_tx_start=1 at edge T: latch i_data into the shift register, enter SEND, set the enable to 1, clear the baud counter and bit index.
- SEND:
  - Frame bit k (k=0 start=0; k=1..8 = i_data[k-1]; k=9 stop=1) drives o_rs232_txd during cycles T+1+k*D through T+(k+1)*D inclusive, i.e. exactly D cycles per bit.
  - The first start-bit cycle is T+1, so latency from strobe to line-low is one cycle.
- Baud generator:
  - While the enable is 1, the counter runs 0..D-1, wraps, and emits a one-cycle tick at count D-1.
  - The tick advances the bit index.
  - While the enable is 0, the counter is held at 0 with no tick.
- Frame end:
  - On the tick ending bit 9, return to IDLE with enable=0.
  - o_tx_done=1 for exactly cycle T+1+10*D; the line is already 1 (idle).
- Start while SEND: ignored. A held or repeated i_tx_start does not restart or corrupt the frame.
- Changes to i_data during SEND: no effect.
- Back-to-back frames: a start sampled in the done cycle, or any later IDLE cycle, is accepted. The next start bit then begins at the following cycle, so there is no mandatory idle gap beyond the done cycle.
- Start held continuously: frames repeat every 10*D+1 cycles.
- Line output is registered with no glitches; o_tx_done and the enable are registered.

Decomposition:
- Shared package uart_pkg:
  - default CLK_FREQ and BAUD_RATE
  - DATA_BITS=8
  - FRAME_BITS=10
  - state enum {IDLE, SEND}
- One sub-module, uart_baud_tick:
  - Parameter BAUD_DIV.
  - Inputs clk, rst_n, en; output tick.
  - Counter width is $clog2(BAUD_DIV).
- The serializer FSM, shift register and bit index live in the top.

Test Plan:
- Reset: BAUD_DIV=16; hold rst_n=1 for 3 cycles mid-idle, then mid-frame → txd=1, en=0, done=0 the cycle after reset; the aborted frame produces no done pulse.
- Single frame: BAUD_DIV=16, i_data=8'hA5, one-cycle start at T.
  - Line sequence sampled at bit centres: 0,1,0,1,0,0,1,0,1,1.
  - Each bit is 16 cycles long.
  - done=1 only at T+161.
  - en=1 from T+1 to T+160.
- Edge values: i_data=8'h00 and 8'hFF → line low for 9*D and high for D, and the start bit alone low for D; done timing is identical.
- Ignore-while-busy: strobe start again at T+50 with i_data=8'h3C → the first frame still sends A5 unchanged; the second strobe is discarded; a single done pulse.
- Back-to-back: hold i_tx_start=1 with data 8'h55 then 8'h0F → second start bit begins at T+162; done pulses at T+161 and T+322.
- Default divider: BAUD_DIV=434, i_data=8'h41 → each bit is 434 cycles; done at T+4341.
